hwin_tap: RTL and testbench

//  Horizontal tap-window generator feeding mult_v1 directly. Takes a serial pixel stream
//  (de/hs/vs) and emits, per pixel, the TAP_COUNT horizontally adjacent pixels centred on it
//  as one parallel vector for mult_v1 di_i. Left/right line borders are edge-replicated.

---
 rtl/hwin_tap.sv | 167 ++++++++++++++++
 tb/tb_hwin_tap.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwin_tap.sv
// rtl/hwin_tap.sv - horizontal tap-window generator with edge replication
//
// Purpose: turns a serial pixel stream (de/hs/vs) into, per pixel, the
// TAP_COUNT horizontally adjacent pixels centred on it, presented as one
// parallel vector. Left/right line borders are edge-replicated, so every
// output line has exactly as many beats as the input line had pixels.
//
// Ports:
//   clk   in   1                      clock
//   rst   in   1                      asynchronous active-low reset
//   di_i  in   PIXEL_WIDTH            input pixel, valid when de_i=1
//   de_i  in   1                      pixel valid (gaps allowed inside a line)
//   hs_i  in   1                      1 = horizontal blanking
//   vs_i  in   1                      1 = active frame
//   do_o  out  TAP_COUNT*PIXEL_WIDTH  taps; slice 0 = leftmost, slice R = centre
//   de_o  out  1                      do_o valid
//   hs_o  out  1                      hs_i stretched over the flush
//   vs_o  out  1                      vs_i stretched over the flush
module hwin_tap #(
  parameter int PIXEL_WIDTH   = 12,
  parameter int TAP_COUNT     = 3,
  parameter int LINE_SIZE_MAX = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIXEL_WIDTH-1:0]           di_i,
  input  logic                             de_i,
  input  logic                             hs_i,
  input  logic                             vs_i,
  output logic [TAP_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                             de_o,
  output logic                             hs_o,
  output logic                             vs_o
);

  localparam int R  = (TAP_COUNT - 1) / 2;
  localparam int CW = $clog2(R + 2);

  // The counter only has to tell whether more than R pixels were seen, so
  // it saturates at R+1; that value also seeds the flush beat countdown.
  localparam logic [CW-1:0] C_R    = CW'(R);
  localparam logic [CW-1:0] C_FULL = CW'(R + 1);
  localparam logic [CW-1:0] C_LAST = CW'(2);

  if (TAP_COUNT < 3 || TAP_COUNT > 9 || (TAP_COUNT % 2) == 0 || LINE_SIZE_MAX < 2) begin : g_param_check
    $error("hwin_tap: TAP_COUNT must be odd in 3..9 and LINE_SIZE_MAX >= 2");
  end

  typedef enum logic [1:0] {
    S_WAIT_BLANK = 2'd0,
    S_IDLE       = 2'd1,
    S_RUN        = 2'd2,
    S_FLUSH      = 2'd3
  } state_t;

  state_t                             r_state;
  logic [CW-1:0]                      r_cnt;
  logic [PIXEL_WIDTH-1:0]             r_win [TAP_COUNT];
  logic [TAP_COUNT*PIXEL_WIDTH-1:0]   r_do;
  logic                               r_de;
  logic                               r_hs;
  logic                               r_vs;

  logic [PIXEL_WIDTH-1:0]             w_shift [TAP_COUNT];
  logic [TAP_COUNT*PIXEL_WIDTH-1:0]   w_shift_flat;

  // Window shifted left by one; the new rightmost tap is the incoming pixel
  // while a line runs, and a copy of the current rightmost pixel during the
  // flush (right-edge replication).
  always_comb begin
    for (int i = 0; i < TAP_COUNT - 1; i++) begin
      w_shift[i] = r_win[i+1];
    end
    w_shift[TAP_COUNT-1] = (r_state == S_FLUSH) ? r_win[TAP_COUNT-1] : di_i;
  end

  for (genvar g = 0; g < TAP_COUNT; g++) begin : g_pack
    assign w_shift_flat[g*PIXEL_WIDTH +: PIXEL_WIDTH] = w_shift[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAIT_BLANK;
      r_cnt   <= '0;
      r_do    <= '0;
      r_de    <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b0;
      for (int i = 0; i < TAP_COUNT; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_de <= 1'b0;
      // vs_o stays up until hs_o has risen after the last line of the frame.
      r_vs <= vs_i | (r_vs & ~r_hs);

      case (r_state)
        // Entered only from reset: a line cut by reset is discarded and
        // hs_o keeps its reset value until the next blanking.
        S_WAIT_BLANK: begin
          if (hs_i) begin
            r_state <= S_IDLE;
          end
        end

        S_IDLE: begin
          r_hs <= hs_i;
          if (de_i && !hs_i) begin
            // Left-edge replication: the first pixel fills the whole window.
            for (int i = 0; i < TAP_COUNT; i++) begin
              r_win[i] <= di_i;
            end
            r_cnt   <= CW'(1);
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (hs_i) begin
            if (r_cnt > C_R) begin
              r_state <= S_FLUSH;
            end else begin
              // Too short to centre any pixel: drop the line.
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_hs    <= 1'b1;
            end
          end else if (de_i) begin
            for (int i = 0; i < TAP_COUNT; i++) begin
              r_win[i] <= w_shift[i];
            end
            if (r_cnt != C_FULL) begin
              r_cnt <= r_cnt + CW'(1);
            end
            r_do <= w_shift_flat;
            r_de <= (r_cnt >= C_R);
          end
        end

        S_FLUSH: begin
          // R back-to-back beats, counting r_cnt down from R+1 to 2.
          for (int i = 0; i < TAP_COUNT; i++) begin
            r_win[i] <= w_shift[i];
          end
          r_do <= w_shift_flat;
          r_de <= 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        default: begin
          r_state <= S_WAIT_BLANK;
        end
      endcase
    end
  end

  assign do_o = r_do;
  assign de_o = r_de;
  assign hs_o = r_hs;
  assign vs_o = r_vs;

endmodule

// File: tb/tb_hwin_tap.sv
// tb/tb_hwin_tap.sv - directed self-checking bench for hwin_tap (3 and 5 taps)
module tb_hwin_tap;

  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] di;
  logic          de;
  logic          hs;
  logic          vs;

  logic [3*PW-1:0] do3;
  logic            de3, hs3, vs3;
  logic [5*PW-1:0] do5;
  logic            de5, hs5, vs5;

  hwin_tap #(.PIXEL_WIDTH(PW), .TAP_COUNT(3), .LINE_SIZE_MAX(4096)) dut3 (
    .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
    .do_o(do3), .de_o(de3), .hs_o(hs3), .vs_o(vs3)
  );

  hwin_tap #(.PIXEL_WIDTH(PW), .TAP_COUNT(5), .LINE_SIZE_MAX(4096)) dut5 (
    .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
    .do_o(do5), .de_o(de5), .hs_o(hs5), .vs_o(vs5)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_step;

  logic [3*PW-1:0] q3[$];
  int              qc3[$];
  logic [5*PW-1:0] q5[$];
  int              qc5[$];
  logic [PW-1:0]   pix[$];

  logic hs3_p = 1'b1, hs5_p = 1'b1, vs3_p = 1'b0;
  int   hs3_rise = -1, hs3_fall = -1, hs5_rise = -1, vs3_fall = -1;

  function automatic logic [3*PW-1:0] pack3(input int a, input int b, input int c);
    return {PW'(c), PW'(b), PW'(a)};
  endfunction

  function automatic logic [5*PW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {PW'(e), PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  // Reference: tap j of the window centred on pixel x, edges clamped.
  function automatic logic [PW-1:0] tap(input int x, input int j, input int r);
    int k;
    k = x - r + j;
    if (k < 0) k = 0;
    if (k > pix.size() - 1) k = pix.size() - 1;
    return pix[k];
  endfunction

  function automatic logic [3*PW-1:0] exp3(input int x);
    return {tap(x, 2, 1), tap(x, 1, 1), tap(x, 0, 1)};
  endfunction

  function automatic logic [5*PW-1:0] exp5(input int x);
    return {tap(x, 4, 2), tap(x, 3, 2), tap(x, 2, 2), tap(x, 1, 2), tap(x, 0, 2)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (de3 === 1'b1) begin q3.push_back(do3); qc3.push_back(cyc); end
    if (de5 === 1'b1) begin q5.push_back(do5); qc5.push_back(cyc); end
    if (!hs3_p && hs3) hs3_rise = cyc;
    if (hs3_p && !hs3) hs3_fall = cyc;
    if (!hs5_p && hs5) hs5_rise = cyc;
    if (vs3_p && !vs3) vs3_fall = cyc;
    hs3_p = hs3;
    hs5_p = hs5;
    vs3_p = vs3;
  endtask

  task automatic clear();
    q3.delete(); qc3.delete(); q5.delete(); qc5.delete();
    hs3_rise = -1; hs3_fall = -1; hs5_rise = -1; vs3_fall = -1;
  endtask

  task automatic send_line(input int gap, input int blank, input bit junk, input bit last);
    hs = 1'b0;
    vs = 1'b1;
    foreach (pix[i]) begin
      di = pix[i];
      de = 1'b1;
      step();
      de = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
    hs = 1'b1;
    if (last) vs = 1'b0;
    hs_step = cyc + 1;
    for (int b = 0; b < blank; b++) begin
      de = junk;
      di = PW'(777);
      step();
    end
    de = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; di = '0; de = 1'b0; hs = 1'b1; vs = 1'b1;
    repeat (3) step();
    total++; if (do3 !== '0)   begin bad++; $display("FAIL reset_do3 got=%h exp=0", do3); end
    total++; if (de3 !== 1'b0) begin bad++; $display("FAIL reset_de3 got=%b exp=0", de3); end
    total++; if (hs3 !== 1'b1) begin bad++; $display("FAIL reset_hs3 got=%b exp=1", hs3); end
    total++; if (vs3 !== 1'b0) begin bad++; $display("FAIL reset_vs3 got=%b exp=0", vs3); end
    total++; if (do5 !== '0)   begin bad++; $display("FAIL reset_do5 got=%h exp=0", do5); end
    rst = 1'b1; vs = 1'b0;
    repeat (3) step();
    vs = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_basic();
    logic [3*PW-1:0] e[4];
    int start;
    e[0] = pack3(10, 10, 20); e[1] = pack3(10, 20, 30);
    e[2] = pack3(20, 30, 40); e[3] = pack3(30, 40, 40);
    clear();
    pix = '{PW'(10), PW'(20), PW'(30), PW'(40)};
    start = cyc;
    send_line(0, 8, 1'b0, 1'b0);
    total++; if (q3.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", q3.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= q3.size() || q3[i] !== e[i]) begin
        bad++; $display("FAIL basic_beat%0d got=%h exp=%h", i, (i < q3.size()) ? q3[i] : '0, e[i]);
      end
    end
    total++; if (qc3.size() == 0 || qc3[0] != start + 2) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", (qc3.size() > 0) ? qc3[0] : -1, start + 2); end
    total++; if (hs3_fall != start + 1) begin bad++; $display("FAIL basic_hs_fall got=%0d exp=%0d", hs3_fall, start + 1); end
    total++; if (qc3.size() == 0 || hs3_rise != qc3[$] + 1) begin bad++; $display("FAIL basic_hs_rise got=%0d exp=%0d", hs3_rise, (qc3.size() > 0) ? qc3[$] + 1 : -1); end
  endtask

  task automatic test_gap();
    logic [3*PW-1:0] e[4];
    e[0] = pack3(10, 10, 20); e[1] = pack3(10, 20, 30);
    e[2] = pack3(20, 30, 40); e[3] = pack3(30, 40, 40);
    clear();
    pix = '{PW'(10), PW'(20), PW'(30), PW'(40)};
    send_line(1, 8, 1'b0, 1'b0);
    total++; if (q3.size() != 4) begin bad++; $display("FAIL gap_count got=%0d exp=4", q3.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= q3.size() || q3[i] !== e[i]) begin
        bad++; $display("FAIL gap_beat%0d got=%h exp=%h", i, (i < q3.size()) ? q3[i] : '0, e[i]);
      end
    end
  endtask

  task automatic test_short_line();
    clear();
    pix = '{PW'(7), PW'(9)};
    send_line(0, 8, 1'b0, 1'b0);
    total++; if (q5.size() != 0) begin bad++; $display("FAIL short_count got=%0d exp=0", q5.size()); end
    total++; if (hs5_rise != hs_step) begin bad++; $display("FAIL short_hs_rise got=%0d exp=%0d", hs5_rise, hs_step); end

    clear();
    pix.delete();
    for (int x = 0; x < 6; x++) pix.push_back(PW'(x));
    send_line(0, 8, 1'b0, 1'b0);
    total++; if (q5.size() != 6) begin bad++; $display("FAIL ramp5_count got=%0d exp=6", q5.size()); end
    total++; if (q5.size() < 1 || q5[0] !== pack5(0, 0, 0, 1, 2)) begin bad++; $display("FAIL ramp5_first got=%h exp=%h", (q5.size() > 0) ? q5[0] : '0, pack5(0, 0, 0, 1, 2)); end
    total++; if (q5.size() < 6 || q5[5] !== pack5(3, 4, 5, 5, 5)) begin bad++; $display("FAIL ramp5_last got=%h exp=%h", (q5.size() > 5) ? q5[5] : '0, pack5(3, 4, 5, 5, 5)); end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (i >= q5.size() || q5[i] !== exp5(i)) begin
        bad++; $display("FAIL ramp5_beat%0d got=%h exp=%h", i, (i < q5.size()) ? q5[i] : '0, exp5(i));
      end
    end
    total++; if (qc5.size() < 6 || qc5[4] != hs_step + 1 || qc5[5] != hs_step + 2) begin bad++; $display("FAIL ramp5_flush_timing got=%0d,%0d exp=%0d,%0d", (qc5.size() > 5) ? qc5[4] : -1, (qc5.size() > 5) ? qc5[5] : -1, hs_step + 1, hs_step + 2); end
    total++; if (qc5.size() == 0 || hs5_rise != qc5[$] + 1) begin bad++; $display("FAIL ramp5_hs_rise got=%0d exp=%0d", hs5_rise, (qc5.size() > 0) ? qc5[$] + 1 : -1); end
  endtask

  task automatic test_frames();
    for (int f = 0; f < 2; f++) begin
      hs = 1'b1; vs = 1'b1;
      repeat (4) step();
      for (int l = 0; l < 3; l++) begin
        pix.delete();
        for (int x = 0; x < 12; x++) pix.push_back(PW'(4090 + x));
        clear();
        send_line(0, 8, 1'b0, l == 2);
        total++; if (q3.size() != 12) begin bad++; $display("FAIL frame%0d_line%0d_count3 got=%0d exp=12", f, l, q3.size()); end
        total++; if (q5.size() != 12) begin bad++; $display("FAIL frame%0d_line%0d_count5 got=%0d exp=12", f, l, q5.size()); end
        for (int x = 0; x < 12; x++) begin
          total++;
          if (x >= q3.size() || q3[x] !== exp3(x)) begin
            bad++; $display("FAIL frame%0d_line%0d_t3_px%0d got=%h exp=%h", f, l, x, (x < q3.size()) ? q3[x] : '0, exp3(x));
          end
          total++;
          if (x >= q5.size() || q5[x] !== exp5(x)) begin
            bad++; $display("FAIL frame%0d_line%0d_t5_px%0d got=%h exp=%h", f, l, x, (x < q5.size()) ? q5[x] : '0, exp5(x));
          end
        end
        if (l == 2) begin
          total++;
          if (hs3_rise < 0 || vs3_fall != hs3_rise + 1) begin
            bad++; $display("FAIL frame%0d_vs_fall got=%0d exp=%0d", f, vs3_fall, hs3_rise + 1);
          end
        end
      end
      repeat (5) step();
    end
  endtask

  task automatic test_reset_midline();
    hs = 1'b1; vs = 1'b1;
    repeat (4) step();
    pix.delete();
    for (int x = 0; x < 20; x++) pix.push_back(PW'(100 + x));
    clear();
    hs = 1'b0;
    for (int x = 0; x < 10; x++) begin di = pix[x]; de = 1'b1; step(); end
    rst = 1'b0;
    #1;
    total++; if (do3 !== '0)   begin bad++; $display("FAIL midrst_do3 got=%h exp=0", do3); end
    total++; if (de3 !== 1'b0) begin bad++; $display("FAIL midrst_de3 got=%b exp=0", de3); end
    total++; if (hs3 !== 1'b1) begin bad++; $display("FAIL midrst_hs3 got=%b exp=1", hs3); end
    total++; if (vs3 !== 1'b0) begin bad++; $display("FAIL midrst_vs3 got=%b exp=0", vs3); end
    repeat (2) step();
    rst = 1'b1;
    clear();
    for (int x = 10; x < 20; x++) begin di = pix[x]; de = 1'b1; step(); end
    de = 1'b0;
    total++; if (hs3 !== 1'b1) begin bad++; $display("FAIL midrst_hs_hold got=%b exp=1", hs3); end
    hs = 1'b1;
    repeat (8) step();
    total++; if (q3.size() != 0 || q5.size() != 0) begin bad++; $display("FAIL midrst_dropped got=%0d/%0d exp=0/0", q3.size(), q5.size()); end

    pix = '{PW'(50), PW'(60), PW'(70), PW'(80), PW'(90)};
    clear();
    send_line(0, 8, 1'b0, 1'b0);
    total++; if (q3.size() != 5) begin bad++; $display("FAIL midrst_next_count got=%0d exp=5", q3.size()); end
    for (int x = 0; x < 5; x++) begin
      total++;
      if (x >= q3.size() || q3[x] !== exp3(x)) begin
        bad++; $display("FAIL midrst_next_px%0d got=%h exp=%h", x, (x < q3.size()) ? q3[x] : '0, exp3(x));
      end
    end
  endtask

  task automatic test_ignore();
    logic [3*PW-1:0] e3[3];
    logic [5*PW-1:0] e5[3];
    e3[0] = pack3(100, 100, 200); e3[1] = pack3(100, 200, 300); e3[2] = pack3(200, 300, 300);
    e5[0] = pack5(100, 100, 100, 200, 300);
    e5[1] = pack5(100, 100, 200, 300, 300);
    e5[2] = pack5(100, 200, 300, 300, 300);
    clear();
    hs = 1'b1; vs = 1'b1; de = 1'b1; di = PW'(999);
    repeat (4) step();
    de = 1'b0;
    total++; if (q3.size() != 0 || q5.size() != 0) begin bad++; $display("FAIL ignore_blank got=%0d/%0d exp=0/0", q3.size(), q5.size()); end
    pix = '{PW'(100), PW'(200), PW'(300)};
    send_line(0, 8, 1'b1, 1'b0);
    total++; if (q3.size() != 3) begin bad++; $display("FAIL ignore_count3 got=%0d exp=3", q3.size()); end
    total++; if (q5.size() != 3) begin bad++; $display("FAIL ignore_count5 got=%0d exp=3", q5.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= q3.size() || q3[i] !== e3[i]) begin
        bad++; $display("FAIL ignore_t3_beat%0d got=%h exp=%h", i, (i < q3.size()) ? q3[i] : '0, e3[i]);
      end
      total++;
      if (i >= q5.size() || q5[i] !== e5[i]) begin
        bad++; $display("FAIL ignore_t5_beat%0d got=%h exp=%h", i, (i < q5.size()) ? q5[i] : '0, e5[i]);
      end
    end
    total++; if (do3 !== e3[2]) begin bad++; $display("FAIL ignore_do_hold got=%h exp=%h", do3, e3[2]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_short_line();
    test_frames();
    test_reset_midline();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
